// File: rtl/square_move_queue.sv
// Move snapshot queue: latches N_CH move words, drains the nonzero
// ones one per cycle over a valid/ready port. Define
// SQUARE_MOVE_QUEUE_CAPTURE_FIRST_EN for capture-priority ordering.
// Ports: clk, clear_n (async low), snap, move_in[N_CH*MOVE_W],
// out_ready -> out_valid, move_out, out_ch, busy, done, count.
module square_move_queue #(
  parameter int N_CH    = 16,
  parameter int MOVE_W  = 40,
  parameter int CAP_LSB = 24
) (
  input  logic                       clk,
  input  logic                       clear_n,
  input  logic                       snap,
  input  logic [N_CH*MOVE_W-1:0]     move_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [MOVE_W-1:0]          move_out,
  output logic [$clog2(N_CH)-1:0]    out_ch,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_CH+1)-1:0]  count
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int CNT_W = $clog2(N_CH+1);

  if (CAP_LSB + 6 > MOVE_W) begin : g_bad_cap
    $error("capture field exceeds move word");
  end

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_t;

  state_t state;

  logic [N_CH-1:0][MOVE_W-1:0] buffer;
  logic [N_CH-1:0][MOVE_W-1:0] in_words;
  logic [N_CH-1:0][MOVE_W-1:0] words;
  logic [N_CH-1:0]             pending;
  logic [N_CH-1:0]             pend_nx;
  logic [CH_W-1:0]             sel;
  logic                        snap_take;
  logic                        accept;

  assign in_words  = move_in;
  assign snap_take = (state == IDLE) && snap;
  assign accept    = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Selection looks at next-cycle pending so move_out can be
  // registered while still sustaining one handoff per cycle.
  always_comb begin
    words   = snap_take ? in_words : buffer;
    pend_nx = pending;
    if (snap_take) begin
      for (int c = 0; c < N_CH; c++)
        pend_nx[c] = (in_words[c] != '0);
    end else if (accept) begin
      pend_nx[out_ch] = 1'b0;
    end
    sel = '0;
    for (int c = N_CH-1; c >= 0; c--)
      if (pend_nx[c]) sel = CH_W'(c);
`ifdef SQUARE_MOVE_QUEUE_CAPTURE_FIRST_EN
    for (int c = N_CH-1; c >= 0; c--)
      if (pend_nx[c] && (words[c][CAP_LSB +: 6] != '0))
        sel = CH_W'(c);
`endif
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      buffer    <= '0;
      pending   <= '0;
      out_valid <= 1'b0;
      move_out  <= '0;
      out_ch    <= '0;
      count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (snap) begin
            buffer    <= in_words;
            pending   <= pend_nx;
            count     <= '0;
            state     <= DRAIN;
            out_valid <= |pend_nx;
            move_out  <= words[sel];
            out_ch    <= sel;
          end
        end
        DRAIN: begin
          pending <= pend_nx;
          if (accept) count <= count + CNT_W'(1);
          if (pend_nx == '0) begin
            state     <= DONE;
            out_valid <= 1'b0;
            move_out  <= '0;
            out_ch    <= '0;
          end else begin
            out_valid <= 1'b1;
            move_out  <= words[sel];
            out_ch    <= sel;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_square_move_queue.sv
// Randomized bench for square_move_queue against a queue model
// that orders moves by index (capture-first when the macro is set).
module tb_square_move_queue;

  localparam int N = 16;
  localparam int W = 40;
  localparam int C = 24;

  logic           clk = 1'b0;
  logic           clear_n = 1'b0;
  logic           snap = 1'b0;
  logic [N*W-1:0] move_in = '0;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [W-1:0]   move_out;
  logic [3:0]     out_ch;
  logic           busy;
  logic           done;
  logic [4:0]     count;

  int vectors = 0;
  int errors  = 0;

  square_move_queue #(.N_CH(N), .MOVE_W(W), .CAP_LSB(C)) dut (
    .clk(clk), .clear_n(clear_n), .snap(snap),
    .move_in(move_in), .out_ready(out_ready),
    .out_valid(out_valid), .move_out(move_out),
    .out_ch(out_ch), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] wd(input logic [N*W-1:0] v,
                                      input int c);
    return v[c*W +: W];
  endfunction

  function automatic logic [N*W-1:0] rand_mv(input int pct);
    logic [N*W-1:0] v = '0;
    logic [W-1:0]   w;
    for (int c = 0; c < N; c++) begin
      if ($urandom_range(99) < pct) begin
        w = {$urandom, $urandom};
        if ($urandom_range(1) == 0) w[C +: 6] = '0;
        if (w == '0) w[0] = 1'b1;
        v[c*W +: W] = w;
      end
    end
    return v;
  endfunction

  task automatic run_snap(input logic [N*W-1:0] mv,
                          input int ready_pct,
                          input int stall,
                          input bit noise);
    int q[$];
    int exp_cnt = 0;
    int cyc = 0;
    bit fin = 0;
    bit rdy;
`ifdef SQUARE_MOVE_QUEUE_CAPTURE_FIRST_EN
    for (int c = 0; c < N; c++)
      if (wd(mv, c) != '0 && wd(mv, c)[C +: 6] != '0) q.push_back(c);
    for (int c = 0; c < N; c++)
      if (wd(mv, c) != '0 && wd(mv, c)[C +: 6] == '0) q.push_back(c);
`else
    for (int c = 0; c < N; c++)
      if (wd(mv, c) != '0) q.push_back(c);
`endif
    snap = 1'b1;
    move_in = mv;
    @(negedge clk);
    forever begin
      if (!fin) begin
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1 ||
            out_valid !== (q.size() > 0) ||
            count !== 5'(exp_cnt)) begin
          errors++;
          $display("FAIL drain_ctl cyc %0d: valid=%b busy=%b done=%b cnt=%0d, want valid=%b busy=1 done=0 cnt=%0d",
                   cyc, out_valid, busy, done, count,
                   q.size() > 0, exp_cnt);
        end
        if (q.size() > 0) begin
          vectors++;
          if (out_ch !== 4'(q[0]) || move_out !== wd(mv, q[0])) begin
            errors++;
            $display("FAIL drain_data cyc %0d: ch=%0d word=%h, want ch=%0d word=%h",
                     cyc, out_ch, move_out, q[0], wd(mv, q[0]));
          end
        end
        rdy = (cyc < stall) ? 1'b0 : ($urandom_range(99) < ready_pct);
        out_ready = rdy;
        if (q.size() == 0) fin = 1;
        else if (rdy) begin
          void'(q.pop_front());
          exp_cnt++;
          if (q.size() == 0) fin = 1;
        end
        snap = noise ? 1'($urandom_range(1)) : 1'b0;
        move_in = noise ? rand_mv(60) : mv;
      end else begin
        vectors++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 ||
            count !== 5'(exp_cnt)) begin
          errors++;
          $display("FAIL done_pulse: done=%b busy=%b valid=%b cnt=%0d, want 1 1 0 %0d",
                   done, busy, out_valid, count, exp_cnt);
        end
        snap = 1'b0;
        out_ready = 1'($urandom_range(1));
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || count !== 5'(exp_cnt)) begin
          errors++;
          $display("FAIL idle_after: done=%b busy=%b cnt=%0d, want 0 0 %0d",
                   done, busy, count, exp_cnt);
        end
        break;
      end
      @(negedge clk);
      cyc++;
      if (cyc > 300) begin
        errors++;
        $display("FAIL timeout: no done after %0d cycles, want done", cyc);
        snap = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        count !== 5'd0 || move_out !== '0 || out_ch !== 4'd0) begin
      errors++;
      $display("FAIL reset: valid=%b busy=%b done=%b cnt=%0d ch=%0d word=%h, want all 0",
               out_valid, busy, done, count, out_ch, move_out);
    end
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [N*W-1:0] mv = '0;
    mv[2*W +: W] = 40'h12;
    mv[5*W +: W] = 40'h0000abcd00;
    mv[9*W +: W] = 40'h8000000001;
    run_snap(mv, 100, 0, 0);
  endtask

  task automatic test_empty;
    run_snap('0, 100, 0, 0);
  endtask

  task automatic test_stall;
    logic [N*W-1:0] mv = '0;
    mv[0 +: W] = 40'h5a5a5a5a5a;
    run_snap(mv, 100, 5, 0);
  endtask

  task automatic test_ignore_snap;
    for (int i = 0; i < 4; i++) run_snap(rand_mv(50), 70, 0, 1);
  endtask

  task automatic test_capture_order;
    logic [N*W-1:0] mv = '0;
    mv[1*W +: W] = 40'h1;
    mv[4*W +: W] = 40'h0021000000;
    mv[7*W +: W] = 40'h7;
    run_snap(mv, 100, 0, 0);
  endtask

  task automatic test_reset_mid;
    logic [N*W-1:0] mv = '0;
    mv[0*W +: W] = 40'h3;
    mv[3*W +: W] = 40'h30;
    mv[6*W +: W] = 40'h300;
    snap = 1'b1;
    move_in = mv;
    out_ready = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    @(negedge clk);
    #2 clear_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || count !== 5'd0 ||
        done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b busy=%b cnt=%0d done=%b, want 0 0 0 0",
               out_valid, busy, count, done);
    end
    @(negedge clk);
    clear_n = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_quiet %0d: done=%b valid=%b busy=%b, want 0 0 0",
                 i, done, out_valid, busy);
      end
    end
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++)
      run_snap(rand_mv($urandom_range(100)), $urandom_range(30, 100),
               $urandom_range(3), 0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++) run_snap(rand_mv(80), 100, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_stall();
    test_ignore_snap();
    test_capture_order();
    test_reset_mid();
    test_basic();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/square_move_queue.md
SQUARE_MOVE_QUEUE -- requirements
Module: square_move_queue

Interface
REQ-001 Parameter N_CH, default 16, number of move channels per square (8 sliding + 8 knight).
REQ-002 Parameter MOVE_W, default 40, width of one move word.
REQ-003 Parameter CAP_LSB, default 24, LSB of the 6-bit captured-piece field inside a move word.
REQ-004 clk  input  1  single clock; all state SHALL change on rising edge only.
REQ-005 clear_n  input  1  reset, asynchronous, active-low.
REQ-006 snap  input  1  one-cycle request to capture move_in.
REQ-007 move_in  input  N_CH*MOVE_W  channel c occupies bits [c*MOVE_W +: MOVE_W]; all-zero word = no move.
REQ-008 out_ready  input  1  downstream accepts move_out.
REQ-009 out_valid  output  1  move_out holds a pending move.
REQ-010 move_out  output  MOVE_W  registered move word.
REQ-011 out_ch  output  clog2(N_CH)  source channel index of move_out.
REQ-012 busy  output  1  snapshot in progress; snap ignored.
REQ-013 done  output  1  one-cycle pulse, snapshot fully drained.
REQ-014 count  output  clog2(N_CH+1)  moves handed off since last accepted snap.

Function
REQ-015 States IDLE, DRAIN, DONE; reset state IDLE.
REQ-016 IDLE + snap=1: latch all N_CH words into buffer; pending[c]=1 for each nonzero word; count->0; go DRAIN.
REQ-017 snap while busy=1 SHALL be ignored (buffer, pending, count unchanged).
REQ-018 busy=1 in DRAIN and DONE, 0 in IDLE.
REQ-019 DRAIN: out_valid=1 iff pending nonzero; move_out/out_ch = selected pending channel (REQ-020/REQ-031).
REQ-020 Selection order without CAPTURE_FIRST_EN: lowest pending channel index.
REQ-021 First out_valid SHALL appear the cycle after snap is sampled (latency 1).
REQ-022 out_valid=1, out_ready=0: move_out, out_ch held stable.
REQ-023 out_valid=1, out_ready=1 at edge: clear that pending bit, count+1; next pending word presented next cycle (throughput 1 move/cycle).
REQ-024 pending empty in DRAIN (incl. all-zero snapshot): out_valid=0, go DONE next edge.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; count holds until next accepted snap.
REQ-026 out_ready when out_valid=0 SHALL have no effect.

Reset
REQ-027 clear_n=0 asynchronously forces: IDLE, buffer and pending cleared, out_valid=0, move_out=0, out_ch=0, busy=0, done=0, count=0.
REQ-028 Reset mid-DRAIN discards remaining moves, no done pulse.
REQ-029 After clear_n rises, first snap is accepted at the first rising edge.

Configuration
REQ-030 Macro SQUARE_MOVE_QUEUE_CAPTURE_FIRST_EN selects capture-priority ordering.
REQ-031 Defined: pending words with nonzero [CAP_LSB +: 6] emitted first, lowest index; then quiet moves, lowest index.
REQ-032 Undefined: strict lowest-index order (REQ-020); capture field not inspected.

Verification
REQ-033 Reset then snap, channels 2,5,9 nonzero, out_ready=1 -> out_ch 2,5,9 on consecutive cycles from snap+1; done at snap+4; count=3.
REQ-034 Snap, all-zero move_in -> out_valid never 1; done at snap+2; count=0.
REQ-035 Channel 0 nonzero, out_ready=0 for 5 cycles -> move_out and out_ch=0 stable 5 cycles; one handoff after out_ready=1; count=1.
REQ-036 Second snap during DRAIN with different move_in -> ignored; only original moves emitted.
REQ-037 clear_n=0 after 1 of 3 moves -> out_valid=0, busy=0, count=0 immediately, no done pulse.
REQ-038 Macro defined: ch1 quiet, ch4 capture field 6'h21, ch7 quiet -> order 4,1,7; undefined -> 1,4,7.
